// File: rtl/otter.sv
// Shared types and constants for the OTTER multicycle control path.
// State encoding, opcode constants and the execute-class helper.
package otter;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_INTR,
    ST_HALT
  } fsm_state_t;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_LUI    = 7'b0110111;
  localparam opcode_t OP_AUIPC  = 7'b0010111;
  localparam opcode_t OP_JAL    = 7'b1101111;
  localparam opcode_t OP_JALR   = 7'b1100111;
  localparam opcode_t OP_IMM    = 7'b0010011;
  localparam opcode_t OP_REG    = 7'b0110011;

  localparam int ACK_CNT_W  = 16;
  localparam int INIT_CNT_W = 8;

  typedef enum logic [2:0] {
    EX_ALU,
    EX_BRANCH,
    EX_LOAD,
    EX_STORE,
    EX_ILL
  } ex_class_t;

  function automatic ex_class_t op_class(
    input opcode_t op
  );
    ex_class_t c;
    c = EX_ILL;
    unique case (op)
      OP_LOAD:   c = EX_LOAD;
      OP_STORE:  c = EX_STORE;
      OP_BRANCH: c = EX_BRANCH;
      OP_LUI,
      OP_AUIPC,
      OP_JAL,
      OP_JALR,
      OP_IMM,
      OP_REG:    c = EX_ALU;
      default:   c = EX_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_if.sv
// Control bundle between the sequencer FSM and the decoder/datapath.
// The fsm side drives strobes; the dp side drives opcode and memory acks.
interface control_if;
  import otter::*;

  opcode_t    opcode;
  logic       imem_ack;
  logic       dmem_ack;
  logic       intr;
  logic       mie;
  logic       reset;
  logic       pc_we;
  logic       rf_we;
  logic       mem_we;
  logic       mem_re1;
  logic       mem_re2;
  logic       int_taken;
  logic       illegal;
  logic       bus_err;
  fsm_state_t state;

  modport fsm (
    input  opcode, imem_ack, dmem_ack,
    input  intr, mie,
    output reset, pc_we, rf_we, mem_we,
    output mem_re1, mem_re2,
    output int_taken, illegal, bus_err,
    output state
  );

  modport dp (
    output opcode, imem_ack, dmem_ack,
    output intr, mie,
    input  reset, pc_we, rf_we, mem_we,
    input  mem_re1, mem_re2,
    input  int_taken, illegal, bus_err,
    input  state
  );

endinterface

// File: rtl/ack_timer.sv
// Load/count/expire counter used for init hold and ack timeout.
// Saturates at the limit so expired stays high until reloaded.
module ack_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  assign expired = (cnt_q == limit);

  always_ff @(posedge clk) begin
    if (load) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mcu_ctrl_fsm.sv
// OTTER multicycle control FSM with memory handshakes,
// masked interrupt entry and ack timeout halt.
module mcu_ctrl_fsm
  import otter::*;
#(
  parameter int INIT_CYCLES = 1,
  parameter int INTR_EN     = 1,
  parameter int ACK_TIMEOUT = 0
) (
  input logic   clk,
  input logic   rst,
  control_if.fsm ctl
);

  localparam logic [INIT_CNT_W-1:0] INIT_LIM =
    INIT_CNT_W'(INIT_CYCLES - 1);
  localparam int TO_LIM_I =
    (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [ACK_CNT_W-1:0] TO_LIM =
    ACK_CNT_W'(TO_LIM_I);
  localparam logic TO_ON = (ACK_TIMEOUT > 0);
  localparam logic IE_ON = (INTR_EN != 0);

  fsm_state_t state_q;
  fsm_state_t state_d;
  ex_class_t  ex_cls;

  logic is_load_q;
  logic bus_err_q;
  logic init_done;
  logic wait_exp;
  logic wait_clr;
  logic in_wait;
  logic ack;
  logic timeout;
  logic intr_req;
  logic ex_mem;

  logic o_reset;
  logic o_pc_we;
  logic o_rf_we;
  logic o_mem_we;
  logic o_re1;
  logic o_re2;
  logic o_int;
  logic o_ill;

  assign ex_cls   = op_class(ctl.opcode);
  assign ex_mem   = (ex_cls == EX_LOAD) ||
                    (ex_cls == EX_STORE);
  assign intr_req = IE_ON && ctl.intr && ctl.mie;
  assign in_wait  = (state_q == ST_FETCH) ||
                    (state_q == ST_MEM_WAIT);
  assign ack      = (state_q == ST_FETCH) ?
                    ctl.imem_ack : ctl.dmem_ack;
  assign timeout  = TO_ON && in_wait &&
                    wait_exp && !ack;
  assign wait_clr = rst || (state_d != state_q);

  ack_timer #(.W(INIT_CNT_W)) u_init_tmr (
    .clk     (clk),
    .load    (rst),
    .en      (state_q == ST_INIT),
    .limit   (INIT_LIM),
    .expired (init_done)
  );

  // Cleared on every state change, so each wait starts at zero.
  ack_timer #(.W(ACK_CNT_W)) u_wait_tmr (
    .clk     (clk),
    .load    (wait_clr),
    .en      (in_wait),
    .limit   (TO_LIM),
    .expired (wait_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_load_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == ST_EXEC) begin
        is_load_q <= (ex_cls == EX_LOAD);
      end
      if (timeout) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_done) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (ctl.imem_ack)  state_d = ST_EXEC;
        else if (timeout)  state_d = ST_HALT;
      end
      ST_EXEC: begin
        if (ex_mem)        state_d = ST_MEM_WAIT;
        else if (intr_req) state_d = ST_INTR;
        else               state_d = ST_FETCH;
      end
      ST_MEM_WAIT: begin
        if (ctl.dmem_ack) begin
          state_d = intr_req ? ST_INTR : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_INTR: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    o_reset  = 1'b0;
    o_pc_we  = 1'b0;
    o_rf_we  = 1'b0;
    o_mem_we = 1'b0;
    o_re1    = 1'b0;
    o_re2    = 1'b0;
    o_int    = 1'b0;
    o_ill    = 1'b0;
    if (rst) begin
      o_reset = 1'b1;
    end else begin
      unique case (state_q)
        ST_INIT:  o_reset = 1'b1;
        ST_FETCH: o_re1   = 1'b1;
        ST_EXEC: begin
          unique case (1'b1)
            ex_cls == EX_LOAD:   o_re2    = 1'b1;
            ex_cls == EX_STORE:  o_mem_we = 1'b1;
            ex_cls == EX_BRANCH: o_pc_we  = 1'b1;
            ex_cls == EX_ALU: begin
              o_pc_we = 1'b1;
              o_rf_we = 1'b1;
            end
            default: begin
              o_pc_we = 1'b1;
              o_ill   = 1'b1;
            end
          endcase
        end
        ST_MEM_WAIT: begin
          o_re2    = is_load_q;
          o_mem_we = !is_load_q;
          o_pc_we  = ctl.dmem_ack;
          o_rf_we  = ctl.dmem_ack && is_load_q;
        end
        ST_INTR: begin
          o_int   = 1'b1;
          o_pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ctl.reset     = o_reset;
  assign ctl.pc_we     = o_pc_we;
  assign ctl.rf_we     = o_rf_we;
  assign ctl.mem_we    = o_mem_we;
  assign ctl.mem_re1   = o_re1;
  assign ctl.mem_re2   = o_re2;
  assign ctl.int_taken = o_int;
  assign ctl.illegal   = o_ill;
  assign ctl.bus_err   = bus_err_q && !rst;
  assign ctl.state     = rst ? ST_INIT : state_q;

endmodule

// File: doc/mcu_ctrl_fsm.md
# mcu_ctrl_fsm

Parametrised multicycle control FSM for the OTTER core. It sequences fetch, execute, memory-wait, interrupt-entry and halt states, and drives the write/read strobes consumed by the PC, register file and memory. Unlike a fixed-latency sequencer, it handshakes with variable-latency instruction and data memories, takes masked external interrupts at instruction boundaries, and halts on a memory acknowledge timeout. It sits beside the decoder and is connected through the `fsm` side of `control_if`.

## Interface
- `INIT_CYCLES`, default 1: number of cycles `reset` is held after `rst` deasserts; legal range 1..255.
- `INTR_EN`, default 1: 1 enables interrupt entry; 0 means `intr`/`mie` are ignored and `ST_INTR` is unreachable.
- `ACK_TIMEOUT`, default 0: maximum cycles spent in one wait state; 0 means wait forever; legal range 0..65535.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7 (`opcode_t`): opcode of the fetched instruction, valid in `ST_EXEC`.
- `imem_ack` in 1: instruction read complete; sampled in `ST_FETCH`.
- `dmem_ack` in 1: data access complete; sampled in `ST_MEM_WAIT`.
- `intr` in 1: level-sensitive interrupt request.
- `mie` in 1: interrupt enable from CSR.
- `reset` out 1: datapath reset (PC, register file).
- `pc_we`, `rf_we`, `mem_we`, `mem_re1`, `mem_re2` out 1 each: PC write, register write, data write, instruction read, data read.
- `int_taken` out 1: the datapath loads the trap vector and saves the PC this cycle.
- `illegal` out 1: one-cycle pulse on an unrecognised opcode.
- `bus_err` out 1: sticky timeout flag.
- `state` out 3 (`fsm_state_t`): current state, for debug and verification.

## Operation
- States: `ST_INIT`, `ST_FETCH`, `ST_EXEC`, `ST_MEM_WAIT`, `ST_INTR`, `ST_HALT`.
- Outputs are combinational from state and inputs.
- While `rst`=1, `reset`=1 and every other output is 0, regardless of state.
- `ST_INIT`:
  - `reset`=1 for `INIT_CYCLES` cycles, counted by the init counter.
  - Then go to `ST_FETCH`.
- `ST_FETCH`:
  - `mem_re1`=1 while waiting.
  - On `imem_ack`, go to `ST_EXEC`.
- `ST_EXEC`, by opcode:
  - `LOAD`: `mem_re2`=1; go to `ST_MEM_WAIT`.
  - `STORE`: `mem_we`=1; go to `ST_MEM_WAIT`.
  - `BRANCH`: `pc_we`=1.
  - `LUI`, `AUIPC`, `JAL`, `JALR`, `OP_IMM`, `OP_REG`: `pc_we`=1, `rf_we`=1.
  - Any other opcode: `illegal`=1, `pc_we`=1, `rf_we`=0 (executes as a NOP).
- `ST_MEM_WAIT`:
  - Holds the same request (`mem_re2` for a load, `mem_we` for a store) every cycle until `dmem_ack`. A latched `is_load` bit records which request applies.
  - In the `dmem_ack` cycle: `pc_we`=1, plus `rf_we`=1 for a load.
- Completion cycle: any cycle with `pc_we`=1 in `ST_EXEC` or `ST_MEM_WAIT`.
  - If `INTR_EN` && `intr` && `mie` in that cycle, go to `ST_INTR`; otherwise go to `ST_FETCH`.
- `ST_INTR`:
  - One cycle: `int_taken`=1, `pc_we`=1.
  - Then go to `ST_FETCH`.
  - The request is not re-sampled here; a level still asserted is next considered at the following completion cycle.
- Timeout (`ACK_TIMEOUT`>0):
  - The wait counter clears on entry to `ST_FETCH` or `ST_MEM_WAIT` and increments each cycle without the relevant ack.
  - If the ack is absent in the `ACK_TIMEOUT`-th cycle, go to `ST_HALT` and set `bus_err`.
  - An ack in that same cycle wins over the timeout.
- `ST_HALT`: all strobes are 0 and `bus_err`=1; the state is left only by `rst`.
- `rst` mid-operation (any state, including a pending memory wait): next state is `ST_INIT`; counters, `bus_err` and `is_load` clear; the outstanding request is dropped.

## Timing
- Reset values: `state`=`ST_INIT`; `reset`=1; all other outputs 0.
- First `mem_re1` is asserted `INIT_CYCLES` cycles after the first cycle with `rst`=0.
- Latency with zero-wait acks (ack present in the first wait cycle):
  - ALU, jump or branch instruction: 2 cycles (FETCH, EXEC).
  - Load or store: 3 cycles.
  - Interrupt entry: +1 cycle.
- Memory side requirement: a request stays asserted until its ack; ack is ignored outside the matching wait state.

## Structure
- Add to package `otter`:
  - `fsm_state_t` (3-bit enum, states in the order listed).
  - Constant `ACK_CNT_W` = 16.
- Extend `control_if` modport `fsm`:
  - inputs `imem_ack`, `dmem_ack`, `intr`, `mie`;
  - outputs `int_taken`, `illegal`, `bus_err`.
- One sub-module, `ack_timer`:
  - Parametrised load/count/expire counter.
  - Shared by the init count and the wait timeout (one instance each).

## Test plan
- `rst` high 3 cycles, `INIT_CYCLES`=4 → `reset`=1 for 3+4 cycles, then `mem_re1`=1 in `ST_FETCH`.
- `OP_REG` fetch, `imem_ack` held high → EXEC cycle has `pc_we`=`rf_we`=1; the sequence repeats with period 2.
- `LOAD`, `dmem_ack` after 3 wait cycles → `mem_re2` high for 4 cycles (EXEC plus 3 wait cycles); `rf_we`=`pc_we`=1 only in the ack cycle. `STORE` with the same delay → `mem_we` high for 4 cycles, `rf_we` never asserted.
- `intr`=1 with `mie`=0, then `mie`=1 → no entry while masked; after unmasking, `ST_INTR` follows the next completion, with a single cycle of `int_taken`=1 and `pc_we`=1.
- `ACK_TIMEOUT`=5, `imem_ack` never asserted → `ST_HALT` after 5 fetch cycles with `bus_err` sticky; a second case with ack in cycle 5 → no halt.
- `opcode`=7'b1110011 → `illegal` pulse, `rf_we`=0, `pc_we`=1; `rst` during `ST_MEM_WAIT` → `ST_INIT` next cycle, `mem_re2`=0.
